// File: rtl/frame_pkg.sv
// Shared types and defaults for the frame memory responder.
package frame_pkg;

  localparam int H_PIXELS_DEF    = 640;
  localparam int V_LINES_DEF     = 480;
  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int ADDR_W          = 19;
  localparam int PIX_W           = 16;
  localparam int COORD_W         = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ACCESS,
    ST_DONE
  } state_t;

  // Request captured in IDLE; frozen for the whole transaction.
  typedef struct packed {
    logic               is_write;
    logic               use_sel;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [PIX_W-1:0]   data;
  } req_t;

  // Counter width able to hold 0..n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/frame_mem_responder_if.sv
// Request, response and memory-side signals of the frame responder.
interface frame_mem_responder_if;
  import frame_pkg::*;

  // requester side
  logic               Read;
  logic               Write;
  logic               Pixel_select;
  logic               Address_Reset;
  logic [COORD_W-1:0] Row_Data;
  logic [COORD_W-1:0] Col_Data;
  logic [PIX_W-1:0]   Frame_Data;
  logic               Busy;
  logic [PIX_W-1:0]   Rd_Data;
  logic               Rd_Valid;
  logic               Ack;
  logic               Err;

  // memory side
  logic               Mem_Req;
  logic               Mem_We;
  logic [ADDR_W-1:0]  Mem_Addr;
  logic [PIX_W-1:0]   Mem_WrData;
  logic [PIX_W-1:0]   Mem_RdData;
  logic               Mem_Ready;

  // requester plus memory model
  modport master (
    output Read, Write, Pixel_select, Address_Reset, Row_Data, Col_Data, Frame_Data,
    output Mem_RdData, Mem_Ready,
    input  Busy, Rd_Data, Rd_Valid, Ack, Err,
    input  Mem_Req, Mem_We, Mem_Addr, Mem_WrData
  );

  // the responder
  modport slave (
    input  Read, Write, Pixel_select, Address_Reset, Row_Data, Col_Data, Frame_Data,
    input  Mem_RdData, Mem_Ready,
    output Busy, Rd_Data, Rd_Valid, Ack, Err,
    output Mem_Req, Mem_We, Mem_Addr, Mem_WrData
  );

endinterface

// File: rtl/frame_addr_gen.sv
// Pixel address generation: row/col linearisation, range check and the
// wrapping sequential pointer.
module frame_addr_gen
  import frame_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  output logic [ADDR_W-1:0]  lin_addr,
  output logic               in_range,
  output logic [ADDR_W-1:0]  ptr
);

  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_PIXELS);
  localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(H_PIXELS * V_LINES - 1);

  // Full-width product: 479*640+639 still fits in 19 bits.
  assign lin_addr = ADDR_W'(row) * ROW_STRIDE + ADDR_W'(col);
  assign in_range = (32'(row) < 32'(V_LINES)) && (32'(col) < 32'(H_PIXELS));

  // Pointer: clear beats increment, last pixel wraps to 0.
  always_ff @(posedge clk) begin
    if (rst || clr)
      ptr <= '0;
    else if (inc)
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + ADDR_W'(1);
  end

endmodule

// File: rtl/frame_mem_responder.sv
// Frame memory responder: turns level read/write requests into single
// memory accesses with range checking, timeout and strobed completion.
module frame_mem_responder
  import frame_pkg::*;
#(
  parameter int H_PIXELS    = H_PIXELS_DEF,
  parameter int V_LINES     = V_LINES_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input logic                  CLK,
  input logic                  Reset,
  frame_mem_responder_if.slave bus
);

  localparam int                TCNT_W    = cnt_width(MEM_TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  req_t              req;
  logic [TCNT_W-1:0] tcnt;
  logic [ADDR_W-1:0] lin_addr;
  logic [ADDR_W-1:0] ptr;
  logic              in_range;
  logic              ptr_inc;

  // Only a completed pointer-sourced access advances the pointer.
  assign ptr_inc = (state == ST_ACCESS) && bus.Mem_Ready && !req.use_sel;

  frame_addr_gen #(
    .H_PIXELS (H_PIXELS),
    .V_LINES  (V_LINES)
  ) u_addr (
    .clk      (CLK),
    .rst      (Reset),
    .clr      (bus.Address_Reset),
    .inc      (ptr_inc),
    .row      (req.row),
    .col      (req.col),
    .lin_addr (lin_addr),
    .in_range (in_range),
    .ptr      (ptr)
  );

  // Transaction FSM; every output is registered here.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state          <= ST_IDLE;
      req            <= '0;
      tcnt           <= '0;
      bus.Busy       <= 1'b0;
      bus.Rd_Data    <= '0;
      bus.Rd_Valid   <= 1'b0;
      bus.Ack        <= 1'b0;
      bus.Err        <= 1'b0;
      bus.Mem_Req    <= 1'b0;
      bus.Mem_We     <= 1'b0;
      bus.Mem_Addr   <= '0;
      bus.Mem_WrData <= '0;
    end else begin
      bus.Rd_Valid <= 1'b0;
      bus.Ack      <= 1'b0;
      bus.Err      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.Read || bus.Write) begin
            // read wins when both are requested
            req.is_write <= bus.Write && !bus.Read;
            req.use_sel  <= bus.Pixel_select;
            req.row      <= bus.Row_Data;
            req.col      <= bus.Col_Data;
            req.data     <= bus.Frame_Data;
            bus.Busy     <= 1'b1;
            state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (req.use_sel && !in_range) begin
            bus.Err <= 1'b1;
            state   <= ST_DONE;
          end else begin
            bus.Mem_Addr   <= req.use_sel ? lin_addr : ptr;
            bus.Mem_We     <= req.is_write;
            bus.Mem_WrData <= req.data;
            bus.Mem_Req    <= 1'b1;
            tcnt           <= '0;
            state          <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (bus.Mem_Ready) begin
            bus.Mem_Req <= 1'b0;
            bus.Ack     <= 1'b1;
            if (!req.is_write) begin
              bus.Rd_Data  <= bus.Mem_RdData;
              bus.Rd_Valid <= 1'b1;
            end
            state <= ST_DONE;
          end else if (tcnt == TCNT_LAST) begin
            bus.Mem_Req <= 1'b0;
            bus.Err     <= 1'b1;
            state       <= ST_DONE;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        ST_DONE: begin
          bus.Busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_mem_responder.sv
// Bench for frame_mem_responder: vector table plus hand-written corner cases,
// with a strobe scoreboard.
module tb_frame_mem_responder;

  logic CLK;
  logic Reset;

  frame_mem_responder_if bus();

  frame_mem_responder #(
    .H_PIXELS    (640),
    .V_LINES     (480),
    .MEM_TIMEOUT (16)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd, wr, sel, clr;
    logic [9:0]  row, col;
    logic [15:0] wdata, rdata;
    int          delay;      // ACCESS cycles before Mem_Ready; -1 = never
    logic [18:0] exp_addr;
    logic        exp_we, exp_err;
    int          exp_req;    // cycles Mem_Req is seen high
    logic [15:0] exp_rd;     // Rd_Data expected at the strobe
  } vec_t;

  typedef struct {
    logic        ack, err, rv;
    logic [15:0] rd;
  } sb_t;

  sb_t  sbq[$];
  sb_t  sb_e;
  vec_t tbl[12];
  int   tests;
  int   fails;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int rd, input int wr, input int sel, input int clr,
                              input int row, input int col, input int wdata, input int rdata,
                              input int delay, input int exp_addr, input int exp_we,
                              input int exp_err, input int exp_req, input int exp_rd);
    vec_t v;
    v.rd = (rd != 0); v.wr = (wr != 0); v.sel = (sel != 0); v.clr = (clr != 0);
    v.row = 10'(row); v.col = 10'(col);
    v.wdata = 16'(wdata); v.rdata = 16'(rdata);
    v.delay = delay;
    v.exp_addr = 19'(exp_addr);
    v.exp_we = (exp_we != 0); v.exp_err = (exp_err != 0);
    v.exp_req = exp_req;
    v.exp_rd = 16'(exp_rd);
    return v;
  endfunction

  // One transaction: request, memory model, latency and Busy checks.
  task automatic do_txn(input string nm, input vec_t v);
    int          req_cnt;
    int          done_k;
    logic        stable;
    logic [18:0] first_addr;
    sb_t         e;
    @(negedge CLK);
    bus.Read = v.rd; bus.Write = v.wr; bus.Pixel_select = v.sel;
    bus.Row_Data = v.row; bus.Col_Data = v.col; bus.Frame_Data = v.wdata;
    e.ack = !v.exp_err; e.err = v.exp_err; e.rv = !v.exp_err && !v.exp_we; e.rd = v.exp_rd;
    sbq.push_back(e);
    req_cnt = 0; done_k = 0; stable = 1'b1; first_addr = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      bus.Mem_Ready = 1'b0;
      bus.Address_Reset = 1'b0;
      if (k == 1) begin
        chk({nm, ".busy_up"}, 32'(bus.Busy), 32'd1);
        // changes while busy must be ignored
        bus.Read = 1'b0; bus.Write = 1'b0;
        bus.Row_Data = 10'h3ff; bus.Col_Data = 10'h3ff;
        bus.Frame_Data = ~v.wdata; bus.Pixel_select = ~v.sel;
      end
      if (done_k != 0) begin
        chk({nm, ".busy_down"}, 32'(bus.Busy), 32'd0);
        break;
      end
      if (bus.Mem_Req) begin
        req_cnt++;
        if (req_cnt == 1) first_addr = bus.Mem_Addr;
        if (bus.Mem_Addr !== v.exp_addr || bus.Mem_We !== v.exp_we ||
            (v.exp_we && bus.Mem_WrData !== v.wdata)) stable = 1'b0;
        if (v.delay >= 0 && req_cnt == v.delay + 1) begin
          bus.Mem_Ready = 1'b1;
          bus.Mem_RdData = v.rdata;
          bus.Address_Reset = v.clr;
        end
      end
      if (bus.Ack || bus.Err || bus.Rd_Valid) done_k = k;
    end
    chk({nm, ".latency"}, 32'(done_k), 32'(2 + v.exp_req));
    chk({nm, ".req_cycles"}, 32'(req_cnt), 32'(v.exp_req));
    chk({nm, ".mem_bus_stable"}, 32'(stable), 32'd1);
    if (v.exp_req > 0) chk({nm, ".mem_addr"}, 32'(first_addr), 32'(v.exp_addr));
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (bus.Ack || bus.Err || bus.Rd_Valid) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: ack=%0b err=%0b rv=%0b, want no strobe",
                 bus.Ack, bus.Err, bus.Rd_Valid);
      end else begin
        sb_e = sbq.pop_front();
        chk("sb_ack", 32'(bus.Ack), 32'(sb_e.ack));
        chk("sb_err", 32'(bus.Err), 32'(sb_e.err));
        chk("sb_rd_valid", 32'(bus.Rd_Valid), 32'(sb_e.rv));
        chk("sb_rd_data", 32'(bus.Rd_Data), 32'(sb_e.rd));
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, ".busy"},     32'(bus.Busy), 32'd0);
    chk({nm, ".mem_req"},  32'(bus.Mem_Req), 32'd0);
    chk({nm, ".mem_we"},   32'(bus.Mem_We), 32'd0);
    chk({nm, ".mem_addr"}, 32'(bus.Mem_Addr), 32'd0);
    chk({nm, ".mem_wdat"}, 32'(bus.Mem_WrData), 32'd0);
    chk({nm, ".rd_data"},  32'(bus.Rd_Data), 32'd0);
    chk({nm, ".rd_valid"}, 32'(bus.Rd_Valid), 32'd0);
    chk({nm, ".ack"},      32'(bus.Ack), 32'd0);
    chk({nm, ".err"},      32'(bus.Err), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //          rd wr sel clr row  col  wdata   rdata   dly addr    we err req rd_exp
    tbl[0]  = mk(1, 0, 1, 0,   2,   5, 'h0000, 'hBEEF,  0,   1285, 0, 0,  1, 'hBEEF);
    tbl[1]  = mk(0, 1, 1, 0, 480,   0, 'h1111, 'h0000,  0,      0, 1, 1,  0, 'hBEEF);
    tbl[2]  = mk(0, 1, 1, 0,   0, 640, 'h2222, 'h0000,  0,      0, 1, 1,  0, 'hBEEF);
    tbl[3]  = mk(0, 1, 1, 0, 479, 639, 'h1234, 'h0000,  2, 307199, 1, 0,  3, 'hBEEF);
    tbl[4]  = mk(1, 0, 1, 0, 100,   0, 'h0000, 'h0A5A,  3,  64000, 0, 0,  4, 'h0A5A);
    tbl[5]  = mk(0, 1, 0, 0,   0,   0, 'h5555, 'h0000,  0,      0, 1, 0,  1, 'h0A5A);
    tbl[6]  = mk(1, 0, 0, 0,   0,   0, 'h0000, 'h7777,  1,      1, 0, 0,  2, 'h7777);
    tbl[7]  = mk(1, 1, 1, 0,   1,   1, 'hAAAA, 'h1111,  0,    641, 0, 0,  1, 'h1111);
    tbl[8]  = mk(1, 0, 0, 0,   0,   0, 'h0000, 'hDEAD, -1,      2, 0, 1, 16, 'h1111);
    tbl[9]  = mk(0, 1, 0, 0,   0,   0, 'h6666, 'h0000,  0,      2, 1, 0,  1, 'h1111);
    tbl[10] = mk(1, 0, 0, 1,   0,   0, 'h0000, 'h2222,  0,      3, 0, 0,  1, 'h2222);
    tbl[11] = mk(0, 1, 0, 0,   0,   0, 'h7070, 'h0000,  0,      0, 1, 0,  1, 'h2222);

    bus.Read = 0; bus.Write = 0; bus.Pixel_select = 0; bus.Address_Reset = 0;
    bus.Row_Data = '0; bus.Col_Data = '0; bus.Frame_Data = '0;
    bus.Mem_RdData = '0; bus.Mem_Ready = 0;
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

    // pointer at the last pixel: write there, then the next access wraps to 0
    @(negedge CLK);
    force dut.u_addr.ptr = 19'd307199;
    @(negedge CLK);
    release dut.u_addr.ptr;
    do_txn("wrap_last", mk(0, 1, 0, 0, 0, 0, 'h4321, 'h0000, 0, 307199, 1, 0, 1, 'h2222));
    do_txn("wrap_zero", mk(1, 0, 0, 0, 0, 0, 'h0000, 'h9999, 0,      0, 0, 0, 1, 'h9999));

    // reset while ACCESS is waiting on memory: no strobe, everything cleared
    @(negedge CLK);
    bus.Read = 1; bus.Write = 1; bus.Pixel_select = 1; bus.Row_Data = 10'd3; bus.Col_Data = 10'd3;
    @(negedge CLK);
    bus.Read = 0; bus.Write = 0;
    @(negedge CLK);
    chk("rst_mid.mem_req", 32'(bus.Mem_Req), 32'd1);
    chk("rst_mid.mem_we", 32'(bus.Mem_We), 32'd0);
    chk("rst_mid.mem_addr", 32'(bus.Mem_Addr), 32'd1923);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    chk_all_zero("rst_mid");
    repeat (3) @(negedge CLK);
    chk("rst_mid.idle", 32'(bus.Busy), 32'd0);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
